// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter for timed game events (jump airtime, cooldowns,
//   animation holds). It counts a programmed number of enabled ticks down
//   to zero and then pulses done for one cycle. It also exposes the elapsed
//   up-count, so consumers of an up-counter can attach unchanged.
//
//   Optional build macro COUNTDOWN_AUTO_RELOAD_EN: when defined, expiry
//   reloads the last accepted interval and keeps running. The exception is
//   a zero-length interval, which still returns to IDLE.
//
// Parameters
//   WIDTH      width of load_val, remaining and elapsed
//
// Ports
//   CLK        system clock; all state changes occur on the rising edge
//   RESET      asynchronous, active-low reset
//   start      begin a countdown from load_val; honoured only in IDLE
//   load_val   interval length in ticks; sampled on an accepted start
//   tick_en    decrement qualifier; one tick is consumed per cycle in RUN
//   pause      level input; holds the count while high
//   abort      cancel the countdown and return to IDLE without done
//   busy       registered; high in RUN or PAUSED
//   done       registered; single-cycle pulse on expiry
//   remaining  registered; ticks left
//   elapsed    registered; ticks consumed since the last accepted start
module countdown_timer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick_en,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] remaining,
   output logic [WIDTH-1:0] elapsed
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      DONE
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] reload_val;
   logic [WIDTH-1:0] reload_nxt;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] el_nxt;

   // busy and done are decoded from the next state, so they are registered
   // together with the state and need no output logic after the flops.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         remaining  <= '0;
         elapsed    <= '0;
         reload_val <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         remaining  <= rem_nxt;
         elapsed    <= el_nxt;
         reload_val <= reload_nxt;
         busy       <= (state_nxt == RUN) || (state_nxt == PAUSED);
         done       <= (state_nxt == DONE);
      end
   end

   always_comb begin
      state_nxt  = state;
      rem_nxt    = remaining;
      el_nxt     = elapsed;
      reload_nxt = reload_val;
      case (state)
         IDLE: begin
            if (start) begin
               el_nxt     = '0;
               // A zero interval also clears reload_val. This keeps
               // auto-reload from re-arming a stale interval.
               reload_nxt = load_val;
               if (load_val != '0) begin
                  rem_nxt   = load_val;
                  state_nxt = RUN;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         RUN: begin
            // The priority is abort, then pause, then tick. A tick that
            // arrives together with pause is dropped.
            if (abort) begin
               rem_nxt   = '0;
               state_nxt = IDLE;
            end else if (pause) begin
               state_nxt = PAUSED;
            end else if (tick_en) begin
               el_nxt = elapsed + ONE;
               // The <= comparison ensures remaining can never wrap below zero.
               if (remaining <= ONE) begin
                  rem_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  rem_nxt = remaining - ONE;
               end
            end
         end
         PAUSED: begin
            // On the release cycle the timer only returns to RUN. A tick
            // in that cycle is not consumed.
            if (abort) begin
               rem_nxt   = '0;
               state_nxt = IDLE;
            end else if (!pause) begin
               state_nxt = RUN;
            end
         end
         DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (reload_val != '0) begin
               rem_nxt   = reload_val;
               el_nxt    = '0;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // While a countdown is in progress, every consumed tick moves exactly
   // one unit from remaining to elapsed.
   a_conserve : assert property (@(posedge CLK) disable iff (!RESET)
      ((state == RUN) || (state == PAUSED)) |-> ((remaining + elapsed) == reload_val));

endmodule
